// File: rtl/feeder_pkg.sv
// -----------------------------------------------------------------------------
// feeder_pkg
// Shared definitions for the instruction feeder slice. It holds the word width,
// the opcode values the feeder decodes and the FSM state encoding.
// Ports: none (package).
// -----------------------------------------------------------------------------
package feeder_pkg;

    localparam int W = 9;

    localparam logic [2:0] OP_MV  = 3'b000;
    localparam logic [2:0] OP_MVI = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b011;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_IMM   = 2'd2,
        S_WAIT  = 2'd3
    } state_t;

    // Any opcode with I[2] set is outside the processor's instruction set.
    function automatic logic is_illegal(input logic [W-1:0] word);
        return word[W-1];
    endfunction

    function automatic logic [2:0] opcode_of(input logic [W-1:0] word);
        return word[W-1:W-3];
    endfunction

endpackage

// File: rtl/instr_feeder_if.sv
// -----------------------------------------------------------------------------
// instr_feeder_if
// Processor-side link between the feeder and the 9-bit processor.
//   DIN  : word presented to the processor (opcode or immediate)
//   Run  : one-cycle instruction strobe
//   Done : processor completion, combinational from the processor
// Modports: master (feeder side), slave (processor side).
// -----------------------------------------------------------------------------
interface instr_feeder_if;
    import feeder_pkg::*;

    logic [W-1:0] DIN;
    logic         Run;
    logic         Done;

    modport master (output DIN, output Run, input Done);
    modport slave  (input DIN, input Run, output Done);

endinterface

// File: rtl/instr_fifo.sv
// -----------------------------------------------------------------------------
// instr_fifo
// Word FIFO that buffers instruction and immediate words from the host.
//   Clock, Resetn : clock, synchronous active-low reset
//   Wr, WrData    : push request and word
//   Pop           : remove the head word
//   Head          : mem[rd_ptr], valid whenever Empty is low
//   Count         : number of stored words
//   Full, Empty   : Count == DEPTH, Count == 0
//   Overflow      : sticky, a push was dropped because the FIFO was full
// DEPTH must be a power of two (pointers wrap by natural overflow), minimum 2.
// -----------------------------------------------------------------------------
module instr_fifo #(
    parameter int DEPTH = 8,
    parameter int W     = 9
) (
    input  logic                   Clock,
    input  logic                   Resetn,
    input  logic                   Wr,
    input  logic [W-1:0]           WrData,
    input  logic                   Pop,
    output logic [W-1:0]           Head,
    output logic [$clog2(DEPTH):0] Count,
    output logic                   Full,
    output logic                   Empty,
    output logic                   Overflow
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          push;
    logic          pop;

    // Full is judged before any same-cycle pop, so a write into a full FIFO
    // is dropped even if the head leaves on the same edge.
    assign Full  = (Count == CW'(DEPTH));
    assign Empty = (Count == '0);
    assign push  = Wr && !Full;
    assign pop   = Pop && !Empty;
    assign Head  = mem[rd_ptr];

    always_ff @(posedge Clock) begin
        if (push) begin
            mem[wr_ptr] <= WrData;
        end
    end

    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            Count    <= '0;
            Overflow <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   Count <= Count + 1'b1;
                2'b01:   Count <= Count - 1'b1;
                default: Count <= Count;
            endcase
            if (Wr && Full) Overflow <= 1'b1;
        end
    end

endmodule

// File: rtl/instr_feeder.sv
// -----------------------------------------------------------------------------
// instr_feeder
// Streams host-loaded instruction words into the 9-bit processor one at a
// time: opcode with a Run strobe, the immediate in the following cycle for
// mvi, then waits for Done before issuing the next instruction.
//   Clock, Resetn : clock, synchronous active-low reset
//   Wr, WrData    : host push into the internal FIFO
//   Enable        : permit issuing (sampled only in IDLE)
//   proc          : DIN/Run out, Done in (instr_feeder_if.master)
//   Full, Empty   : FIFO status
//   Overflow      : sticky, a host write was dropped while Full
//   Illegal       : one-cycle pulse, an opcode with I[2]=1 was discarded
//   Err           : sticky watchdog timeout (0 unless FEEDER_WATCHDOG_EN)
//   InstrCount    : retired instructions, wraps 255 -> 0
// Build option: define FEEDER_WATCHDOG_EN to add the TIMEOUT watchdog on WAIT.
// -----------------------------------------------------------------------------
module instr_feeder
    import feeder_pkg::*;
#(
    parameter int DEPTH = 8
`ifdef FEEDER_WATCHDOG_EN
    ,
    parameter int TIMEOUT = 15
`endif
) (
    input  logic                 Clock,
    input  logic                 Resetn,
    input  logic                 Wr,
    input  logic [W-1:0]         WrData,
    input  logic                 Enable,
    instr_feeder_if.master       proc,
    output logic                 Full,
    output logic                 Empty,
    output logic                 Overflow,
    output logic                 Illegal,
    output logic                 Err,
    output logic [7:0]           InstrCount
);
    localparam int CW = $clog2(DEPTH) + 1;

    state_t          state;
    state_t          state_nxt;
    logic [W-1:0]    head;
    logic [CW-1:0]   count;
    logic            pop;
    logic            illegal_nxt;
    logic            retire;

    instr_fifo #(.DEPTH(DEPTH), .W(W)) u_fifo (
        .Clock    (Clock),
        .Resetn   (Resetn),
        .Wr       (Wr),
        .WrData   (WrData),
        .Pop      (pop),
        .Head     (head),
        .Count    (count),
        .Full     (Full),
        .Empty    (Empty),
        .Overflow (Overflow)
    );

`ifdef FEEDER_WATCHDOG_EN
    localparam int WDW = $clog2(TIMEOUT + 1);
    logic [WDW-1:0] wd_cnt;
    logic           wd_expire;
`endif

    always_comb begin
        state_nxt   = state;
        pop         = 1'b0;
        illegal_nxt = 1'b0;
        retire      = 1'b0;
`ifdef FEEDER_WATCHDOG_EN
        wd_expire   = 1'b0;
`endif
        case (state)
            S_IDLE: begin
                if (Enable && !Empty) begin
                    if (is_illegal(head)) begin
                        pop         = 1'b1;
                        illegal_nxt = 1'b1;
                    end else if (!(opcode_of(head) == OP_MVI && count < CW'(2))) begin
                        // An mvi is only started once its immediate is queued.
                        state_nxt = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                pop       = 1'b1;
                state_nxt = (opcode_of(head) == OP_MVI) ? S_IMM : S_WAIT;
            end
            S_IMM: begin
                pop       = 1'b1;
                retire    = proc.Done;
                state_nxt = S_IDLE;
            end
            S_WAIT: begin
                if (proc.Done) begin
                    retire    = 1'b1;
                    state_nxt = S_IDLE;
                end
`ifdef FEEDER_WATCHDOG_EN
                else if (wd_cnt == WDW'(TIMEOUT - 1)) begin
                    wd_expire = 1'b1;
                    state_nxt = S_IDLE;
                end
`endif
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            state      <= S_IDLE;
            Illegal    <= 1'b0;
            InstrCount <= 8'd0;
        end else begin
            state   <= state_nxt;
            Illegal <= illegal_nxt;
            if (retire) InstrCount <= InstrCount + 8'd1;
        end
    end

    assign proc.Run = (state == S_ISSUE);
    assign proc.DIN = (state == S_ISSUE || state == S_IMM) ? head : '0;

`ifdef FEEDER_WATCHDOG_EN
    // wd_cnt holds the number of WAIT cycles already spent without Done.
    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            wd_cnt <= '0;
            Err    <= 1'b0;
        end else begin
            wd_cnt <= (state == S_WAIT && state_nxt == S_WAIT) ? wd_cnt + 1'b1 : '0;
            if (wd_expire) Err <= 1'b1;
        end
    end
`else
    assign Err = 1'b0;
`endif

endmodule

// File: tb/tb_instr_feeder.sv
// -----------------------------------------------------------------------------
// tb_instr_feeder
// Self-checking bench for instr_feeder. A small processor model answers Run
// with Done (mv/mvi: next cycle, add/sub: third WAIT cycle); a scoreboard
// queue holds the instructions expected on DIN in issue order.
// -----------------------------------------------------------------------------
module tb_instr_feeder;
    import feeder_pkg::*;

    logic       Clock  = 1'b0;
    logic       Resetn = 1'b0;
    logic       Wr     = 1'b0;
    logic [8:0] WrData = '0;
    logic       Enable = 1'b0;
    logic       Full, Empty, Overflow, Illegal, Err;
    logic [7:0] InstrCount;

    instr_feeder_if pif ();

    instr_feeder dut (
        .Clock      (Clock),
        .Resetn     (Resetn),
        .Wr         (Wr),
        .WrData     (WrData),
        .Enable     (Enable),
        .proc       (pif),
        .Full       (Full),
        .Empty      (Empty),
        .Overflow   (Overflow),
        .Illegal    (Illegal),
        .Err        (Err),
        .InstrCount (InstrCount)
    );

    always #5 Clock = ~Clock;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    always @(posedge Clock) cyc <= cyc + 1;

    typedef struct {
        logic [8:0] op;
        logic [8:0] imm;
        bit         has_imm;
    } exp_t;
    exp_t sbq[$];

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Processor model and DIN monitor
    bit         hang     = 1'b0;
    int         dcnt     = 0;
    bit         imm_pend = 1'b0;
    logic [8:0] imm_exp  = '0;
    int         run_cyc  = -100;
    int         run_gap  = 0;
    int         ill_seen = 0;

    initial pif.Done = 1'b0;

    always @(negedge Clock) begin
        exp_t e;
        pif.Done = 1'b0;
        if (!Resetn) begin
            dcnt     = 0;
            imm_pend = 1'b0;
        end else begin
            if (dcnt > 0) begin
                dcnt--;
                if (dcnt == 0) pif.Done = 1'b1;
            end
            if (Illegal) ill_seen++;
            if (imm_pend) begin
                check("imm DIN", pif.DIN, imm_exp);
                imm_pend = 1'b0;
            end else if (pif.Run) begin
                run_gap = cyc - run_cyc;
                run_cyc = cyc;
                if (sbq.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected Run: DIN 0x%0h, expected no issue", pif.DIN);
                end else begin
                    e = sbq.pop_front();
                    check("opcode DIN", pif.DIN, e.op);
                    if (e.has_imm) begin
                        imm_pend = 1'b1;
                        imm_exp  = e.imm;
                    end
                end
                if (!hang) dcnt = (pif.DIN[8:7] == 2'b00) ? 1 : 3;
            end else begin
                check("idle DIN", pif.DIN, 0);
            end
        end
    end

    task automatic push(input logic [8:0] w);
        Wr     = 1'b1;
        WrData = w;
        @(negedge Clock);
        Wr     = 1'b0;
    endtask

    task automatic expect_issue(input logic [8:0] op, input logic [8:0] imm, input bit has_imm);
        exp_t e;
        e.op      = op;
        e.imm     = imm;
        e.has_imm = has_imm;
        sbq.push_back(e);
    endtask

    task automatic wait_count(input logic [7:0] exp, input int budget, input string name);
        int n = 0;
        while (InstrCount != exp && n < budget) begin
            @(negedge Clock);
            n++;
        end
        check(name, InstrCount, exp);
    endtask

    typedef struct {
        logic [8:0] op;
        logic [8:0] imm;
        bit         has_imm;
        int         lat;
        string      name;
    } vec_t;

    initial begin
        vec_t       vt[6];
        logic [7:0] exp_cnt = 8'd0;
        int         ill0;
        int         n;

        vt[0] = '{op: 9'h040, imm: 9'h005, has_imm: 1'b1, lat: 2, name: "mvi R0,5"};
        vt[1] = '{op: 9'h081, imm: 9'h000, has_imm: 1'b0, lat: 4, name: "add R0,R1"};
        vt[2] = '{op: 9'h00A, imm: 9'h000, has_imm: 1'b0, lat: 2, name: "mv R1,R2"};
        vt[3] = '{op: 9'h0D3, imm: 9'h000, has_imm: 1'b0, lat: 4, name: "sub R2,R3"};
        vt[4] = '{op: 9'h07F, imm: 9'h1FF, has_imm: 1'b1, lat: 2, name: "mvi R7,1FF"};
        vt[5] = '{op: 9'h0C0, imm: 9'h000, has_imm: 1'b0, lat: 4, name: "sub R0,R0"};

        // Reset state
        Resetn = 1'b0;
        repeat (3) @(negedge Clock);
        check("reset Run", pif.Run, 0);
        check("reset DIN", pif.DIN, 0);
        check("reset Empty", Empty, 1);
        check("reset Full", Full, 0);
        check("reset Overflow", Overflow, 0);
        check("reset Illegal", Illegal, 0);
        check("reset Err", Err, 0);
        check("reset InstrCount", InstrCount, 0);
        Resetn = 1'b1;
        Enable = 1'b1;
        @(negedge Clock);

        // Single instructions from the table
        for (int i = 0; i < 6; i++) begin
            expect_issue(vt[i].op, vt[i].imm, vt[i].has_imm);
            push(vt[i].op);
            if (vt[i].has_imm) push(vt[i].imm);
            exp_cnt++;
            wait_count(exp_cnt, 50, {vt[i].name, " count"});
            check({vt[i].name, " latency"}, cyc - run_cyc, vt[i].lat);
            check({vt[i].name, " empty"}, Empty, 1);
            @(negedge Clock);
        end

        // Back-to-back add then sub: next Run one IDLE cycle after WAIT ends
        expect_issue(9'h081, 9'h000, 1'b0);
        expect_issue(9'h0C9, 9'h000, 1'b0);
        push(9'h081);
        push(9'h0C9);
        exp_cnt += 8'd2;
        wait_count(exp_cnt, 50, "add/sub pair count");
        check("add->sub Run spacing", run_gap, 5);

        // Split mvi: immediate arrives late
        expect_issue(9'h048, 9'h003, 1'b1);
        push(9'h048);
        check("split mvi hold 1", pif.Run, 0);
        @(negedge Clock);
        check("split mvi hold 2", pif.Run, 0);
        push(9'h003);
        check("split mvi idle after imm", pif.Run, 0);
        @(negedge Clock);
        check("split mvi issue", pif.Run, 1);
        exp_cnt++;
        wait_count(exp_cnt, 20, "split mvi count");

        // Illegal opcode discarded
        ill0 = ill_seen;
        expect_issue(9'h000, 9'h000, 1'b0);
        push(9'h100);
        push(9'h000);
        check("illegal pulse", Illegal, 1);
        check("illegal no Run", pif.Run, 0);
        @(negedge Clock);
        check("illegal pulse ends", Illegal, 0);
        check("issue after illegal", pif.Run, 1);
        exp_cnt++;
        wait_count(exp_cnt, 20, "illegal count");
        check("illegal pulses seen", ill_seen - ill0, 1);

        // Overflow with issuing disabled
        Enable = 1'b0;
        ill0   = ill_seen;
        for (int i = 0; i < 8; i++) begin
            expect_issue(9'(i + 1), 9'h000, 1'b0);
            push(9'(i + 1));
        end
        check("full after 8", Full, 1);
        check("no overflow yet", Overflow, 0);
        check("held while disabled", InstrCount, exp_cnt);
        push(9'h1AA);
        check("overflow set", Overflow, 1);
        check("still full", Full, 1);
        Enable  = 1'b1;
        exp_cnt += 8'd8;
        wait_count(exp_cnt, 100, "overflow drain count");
        @(negedge Clock);
        check("drain empty", Empty, 1);
        check("drain scoreboard", sbq.size(), 0);
        check("dropped word not issued", ill_seen - ill0, 0);

`ifdef FEEDER_WATCHDOG_EN
        // Watchdog: processor never answers
        hang = 1'b1;
        expect_issue(9'h081, 9'h000, 1'b0);
        push(9'h081);
        @(negedge Clock);
        check("wd issue", pif.Run, 1);
        repeat (15) @(negedge Clock);
        check("wd Err before timeout", Err, 0);
        @(negedge Clock);
        check("wd Err set", Err, 1);
        check("wd no retire", InstrCount, exp_cnt);
        hang = 1'b0;
        expect_issue(9'h012, 9'h000, 1'b0);
        push(9'h012);
        exp_cnt++;
        wait_count(exp_cnt, 20, "wd recover count");
        check("wd Err sticky", Err, 1);
`endif

        // Reset in the middle of WAIT
        hang = 1'b1;
        expect_issue(9'h081, 9'h000, 1'b0);
        push(9'h081);
        @(negedge Clock);
        check("mid-wait issue", pif.Run, 1);
        push(9'h011);
        check("queued before reset", Empty, 0);
        Resetn = 1'b0;
        @(negedge Clock);
        check("mid reset Run", pif.Run, 0);
        check("mid reset DIN", pif.DIN, 0);
        check("mid reset Empty", Empty, 1);
        check("mid reset InstrCount", InstrCount, 0);
        check("mid reset Err", Err, 0);
        check("mid reset Overflow", Overflow, 0);
        Resetn  = 1'b1;
        hang    = 1'b0;
        exp_cnt = 8'd0;
        @(negedge Clock);
        check("no issue after reset", sbq.size(), 0);

        // Long stream so the retired counter wraps past 255
        for (int i = 0; i < 260; i++) begin
            n = 0;
            while (Full && n < 100) begin
                @(negedge Clock);
                n++;
            end
            expect_issue(9'(i & 63), 9'h000, 1'b0);
            push(9'(i & 63));
        end
        exp_cnt += 8'd4;
        n = 0;
        while (!(sbq.size() == 0 && Empty) && n < 2000) begin
            @(negedge Clock);
            n++;
        end
        repeat (3) @(negedge Clock);
        check("wrap InstrCount", InstrCount, exp_cnt);
        check("wrap scoreboard", sbq.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL global timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

endmodule
